// File: rtl/test_sequencer.sv
// Test sequencer: holds the DUT in reset for RST_HOLD cycles, then runs it
// and decides PASS / FAIL / TIMEOUT from per-channel done and fail flags.
// The terminal states are absorbing until RST is asserted again.
module test_sequencer #(
  parameter int RST_HOLD = 2,
  parameter int TIMEOUT  = 50000,
  parameter int CHANNELS = 1,
  parameter int CNT_W    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] done,
  input  logic [CHANNELS-1:0] fail,
  output logic                dut_rst,
  output logic                running,
  output logic                finished,
  output logic                passed,
  output logic                timed_out,
  output logic [CHANNELS-1:0] fail_chan,
  output logic [CNT_W-1:0]    cycles
);

  localparam int               HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam bit               TO_EN     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST   = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [CHANNELS-1:0] done_seen_r;

  // Next-state decision: fail beats pass, pass beats timeout.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (|fail) begin
          state_nxt = ST_FAIL;
        end else if (&(done_seen_r | done)) begin
          state_nxt = ST_PASS;
        end else if (TO_EN && (cycles == TO_LAST)) begin
          state_nxt = ST_TIMEOUT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        state_nxt = state_r;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

  // State register plus status flags registered from the next state so they
  // change on the same edge as the state and never glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_HOLD;
      dut_rst   <= 1'b1;
      running   <= 1'b0;
      finished  <= 1'b0;
      passed    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      dut_rst   <= (state_nxt == ST_HOLD);
      running   <= (state_nxt == ST_RUN);
      finished  <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL) ||
                   (state_nxt == ST_TIMEOUT);
      passed    <= (state_nxt == ST_PASS);
      timed_out <= (state_nxt == ST_TIMEOUT);
    end
  end

  // Hold counter: counts HOLD cycles after RST release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt_r <= '0;
    end else if (state_r == ST_HOLD) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // RUN bookkeeping: saturating cycle count and sticky done/fail masks.
  // Also updates on the deciding edge, then freezes once terminal.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cycles      <= '0;
      done_seen_r <= '0;
      fail_chan   <= '0;
    end else if (state_r == ST_RUN) begin
      if (cycles != CNT_MAX) begin
        cycles <= cycles + CNT_W'(1);
      end else begin
        cycles <= cycles;
      end
      done_seen_r <= done_seen_r | done;
      fail_chan   <= fail_chan | fail;
    end else begin
      cycles      <= cycles;
      done_seen_r <= done_seen_r;
      fail_chan   <= fail_chan;
    end
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 The module SHALL have parameter RST_HOLD, default 2: number of cycles dut_rst stays high after RST release; legal values are 1 or more.
REQ-002 The module SHALL have parameter TIMEOUT, default 50000: RUN cycles allowed before timeout; 0 disables the timeout.
REQ-003 The module SHALL have parameter CHANNELS, default 1: number of independent done/fail channels; legal values are 1 or more.
REQ-004 The module SHALL have parameter CNT_W, default 32: width of the cycle counter.
REQ-005 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-006 The module SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port done, input, CHANNELS bits: per-channel completion flags.
REQ-008 The module SHALL have port fail, input, CHANNELS bits: per-channel failure flags.
REQ-009 The module SHALL have port dut_rst, output, 1 bit: active-high reset driven to the device under test (DUT).
REQ-010 The module SHALL have port running, output, 1 bit: high in RUN.
REQ-011 The module SHALL have port finished, output, 1 bit: high in PASS, FAIL or TIMEOUT.
REQ-012 The module SHALL have port passed, output, 1 bit: high only in PASS.
REQ-013 The module SHALL have port timed_out, output, 1 bit: high only in TIMEOUT.
REQ-014 The module SHALL have port fail_chan, output, CHANNELS bits: sticky mask of channels that reported fail.
REQ-015 The module SHALL have port cycles, output, CNT_W bits: count of RUN cycles elapsed.

Function
REQ-016 The module SHALL implement states HOLD, RUN, PASS, FAIL and TIMEOUT, all registered.
REQ-017 In HOLD, dut_rst SHALL be 1; the hold counter increments each cycle; the state moves to RUN on the edge where the hold counter equals RST_HOLD-1, giving exactly RST_HOLD high cycles after RST release.
REQ-018 In RUN, dut_rst SHALL be 0, and cycles SHALL increment by 1 per cycle, saturating at 2^CNT_W-1 with no wrap.
REQ-019 done and fail SHALL be sampled only in RUN; in HOLD and terminal states they are ignored.
REQ-020 A sticky done_seen mask SHALL accumulate done bit-wise in RUN; a channel need not hold done high.
REQ-021 fail_chan SHALL OR in fail each RUN cycle, so it holds every channel that failed up to and including the deciding cycle.
REQ-022 RUN exit priority in a given cycle SHALL be: any fail bit goes to FAIL; else if (done_seen | done) is all ones, go to PASS; else if TIMEOUT is not 0 and cycles equals TIMEOUT-1, go to TIMEOUT; else stay in RUN.
REQ-023 Latency SHALL be one edge: an input seen in RUN cycle k makes finished high starting from the following cycle.
REQ-024 The cycles counter SHALL also increment on the deciding edge, then freeze in terminal states; a timeout therefore leaves cycles equal to TIMEOUT.
REQ-025 Terminal states SHALL be absorbing until RST is asserted, with dut_rst 0 and outputs held stable.
REQ-026 running, finished, passed and timed_out SHALL be decoded directly from state registers, glitch-free.

Reset
REQ-027 While RST is 0, asynchronously: state is HOLD, dut_rst is 1, and running, finished, passed, timed_out, fail_chan, cycles, done_seen and the hold counter are all 0.
REQ-028 RST asserted in any state, including mid-RUN or terminal, SHALL abort immediately with no completion reported; after release the full RST_HOLD sequence repeats.

Verification (RST_HOLD=2, TIMEOUT=8, CHANNELS=2, unless stated)
REQ-029 Release RST with done and fail held at 0 -> dut_rst stays 1 for 2 cycles then 0; after 8 RUN cycles timed_out=1, finished=1, passed=0, cycles=8.
REQ-030 Pulse done[0] in RUN cycle 2 and done[1] in RUN cycle 5 -> PASS on the next edge, passed=1, cycles=6, fail_chan=00.
REQ-031 Drive done=11 and fail=10 in the same RUN cycle -> FAIL, fail_chan=10, passed=0.
REQ-032 Drive fail=01 in RUN cycle 7 (coincides with the timeout) -> FAIL not TIMEOUT, timed_out=0, cycles=8.
REQ-033 Assert RST in RUN cycle 4 -> dut_rst=1 and cycles=0 at once, outputs cleared; after release dut_rst is high for 2 more cycles.
REQ-034 Drive done=11 only during HOLD -> ignored; the block enters RUN and times out as in REQ-029.
